wb_regfile: RTL and testbench

Architectural integer register file (x0–x31) for the RV32I pipeline. It is the consumer end of the MEM/WB writeback interface: it accepts `result_w`, `rd_w` and `RegWrite_w`, commits writes at the clock edge, and serves two combinational decode-stage read ports with optional same-cycle write-through bypass. It also provides a registered debug read port and a committed-write counter used by the testbench and performance monitors.

---
 rtl/rv32_pkg.sv | 13 +
 rtl/wb_regfile_if.sv | 26 ++
 rtl/regfile_read_port.sv | 39 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: data width, register index type and the x0 index.
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xword_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback, decode read, debug read and counter signals of wb_regfile.
interface wb_regfile_if import rv32_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  reg_idx_t          rs1_d;
  reg_idx_t          rs2_d;
  logic [XLEN-1:0]   rd1_d;
  logic [XLEN-1:0]   rd2_d;
  logic [XLEN-1:0]   result_w;
  reg_idx_t          rd_w;
  logic              RegWrite_w;
  reg_idx_t          dbg_addr;
  logic [XLEN-1:0]   dbg_data;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output rs1_d, rs2_d, result_w, rd_w, RegWrite_w, dbg_addr,
    input  rd1_d, rd2_d, dbg_data, wb_count
  );

  modport slave (
    input  rs1_d, rs2_d, result_w, rd_w, RegWrite_w, dbg_addr,
    output rd1_d, rd2_d, dbg_data, wb_count
  );
endinterface

// File: rtl/regfile_read_port.sv
// One decode read port: reset forcing, x0 mask and optional write-through bypass.
// The bypass compare exists only when WB_REGFILE_BYPASS_EN is defined.
module regfile_read_port import rv32_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            force_zero,
  input  reg_idx_t        rs,
  input  logic [XLEN-1:0] stored,
  input  logic            wr_en,
  input  reg_idx_t        wr_idx,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd
);
  logic hit_s;

`ifdef WB_REGFILE_BYPASS_EN
  assign hit_s = wr_en && (wr_idx != REG_ZERO) && (wr_idx == rs);
`else
  logic unused_s;
  assign hit_s    = 1'b0;
  assign unused_s = ^{wr_en, wr_idx, wr_data};
`endif

  // x0 and reset win over the bypass; the bypass wins over stored contents
  always_comb begin
    rd = '0;
    if (force_zero || (rs == REG_ZERO)) begin
      rd = '0;
    end else if (hit_s) begin
`ifdef WB_REGFILE_BYPASS_EN
      rd = wr_data;
`else
      rd = stored;
`endif
    end else begin
      rd = stored;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// RV32I architectural register file x1-x31 at the MEM/WB boundary, with a registered
// debug port and committed-write counter. Optional bypass: WB_REGFILE_BYPASS_EN.
module wb_regfile import rv32_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  logic [XLEN-1:0]  regs_r [1:NUM_REGS-1];
  logic [XLEN-1:0]  dbg_data_r;
  logic [CNT_W-1:0] wb_count_r;
  logic [XLEN-1:0]  stored1_s;
  logic [XLEN-1:0]  stored2_s;
  logic [XLEN-1:0]  dbg_stored_s;
  logic             commit_s;

  assign commit_s = bus.RegWrite_w && (bus.rd_w != REG_ZERO);

  // pre-edge storage lookups; x0 has no storage
  always_comb begin
    stored1_s    = '0;
    stored2_s    = '0;
    dbg_stored_s = '0;
    if (bus.rs1_d != REG_ZERO) begin
      stored1_s = regs_r[bus.rs1_d];
    end else begin
      stored1_s = '0;
    end
    if (bus.rs2_d != REG_ZERO) begin
      stored2_s = regs_r[bus.rs2_d];
    end else begin
      stored2_s = '0;
    end
    if (bus.dbg_addr != REG_ZERO) begin
      dbg_stored_s = regs_r[bus.dbg_addr];
    end else begin
      dbg_stored_s = '0;
    end
  end

  // write commit, debug capture and counter; reset overrides a simultaneous write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      dbg_data_r <= '0;
      wb_count_r <= '0;
    end else begin
      dbg_data_r <= dbg_stored_s;
      if (commit_s) begin
        regs_r[bus.rd_w] <= bus.result_w;
        wb_count_r       <= wb_count_r + CNT_W'(1);
      end
    end
  end

  assign bus.dbg_data = dbg_data_r;
  assign bus.wb_count = wb_count_r;

  regfile_read_port #(.XLEN(XLEN)) u_port1 (
    .force_zero (reset),
    .rs         (bus.rs1_d),
    .stored     (stored1_s),
    .wr_en      (bus.RegWrite_w),
    .wr_idx     (bus.rd_w),
    .wr_data    (bus.result_w),
    .rd         (bus.rd1_d)
  );

  regfile_read_port #(.XLEN(XLEN)) u_port2 (
    .force_zero (reset),
    .rs         (bus.rs2_d),
    .stored     (stored2_s),
    .wr_en      (bus.RegWrite_w),
    .wr_idx     (bus.rd_w),
    .wr_data    (bus.result_w),
    .rd         (bus.rd2_d)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array-based reference model, per-cycle compare,
// directed cases and randomized traffic. A narrow-counter instance exercises wrap.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();
  wb_regfile_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  wb_regfile #(.XLEN(32), .CNT_W(64)) dut (.clk(clk), .reset(rst), .bus(bus.slave));
  wb_regfile #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .reset(rst), .bus(bus4.slave));

  assign bus4.rs1_d      = bus.rs1_d;
  assign bus4.rs2_d      = bus.rs2_d;
  assign bus4.result_w   = bus.result_w;
  assign bus4.rd_w       = bus.rd_w;
  assign bus4.RegWrite_w = bus.RegWrite_w;
  assign bus4.dbg_addr   = bus.dbg_addr;

  always #5 clk = ~clk;

  // reference model: architectural state as a plain array
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  logic [31:0] m_dbg;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt   = 64'd0;
      m_dbg   = 32'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_dbg = m_regs[bus.dbg_addr];
      if (bus.RegWrite_w && bus.rd_w != 5'd0) begin
        m_regs[bus.rd_w] = bus.result_w;
        m_cnt = m_cnt + 64'd1;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (rst || rs == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (bus.RegWrite_w && bus.rd_w != 5'd0 && bus.rd_w == rs) return bus.result_w;
`endif
    return m_regs[rs];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle once the model holds a known state
  always @(negedge clk) begin
    if (m_valid) begin
      check("rd1_d", {32'd0, bus.rd1_d}, {32'd0, exp_rd(bus.rs1_d)});
      check("rd2_d", {32'd0, bus.rd2_d}, {32'd0, exp_rd(bus.rs2_d)});
      check("dbg_data", {32'd0, bus.dbg_data}, {32'd0, m_dbg});
      check("wb_count", bus.wb_count, m_cnt);
      check("wb_count4", {60'd0, bus4.wb_count}, {60'd0, m_cnt[3:0]});
      check("rd1_d_w4", {32'd0, bus4.rd1_d}, {32'd0, exp_rd(bus.rs1_d)});
    end
  end

  task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] dbg);
    @(posedge clk);
    #1;
    rst            = r;
    bus.RegWrite_w = we;
    bus.rd_w       = rd;
    bus.result_w   = d;
    bus.rs1_d      = a;
    bus.rs2_d      = b;
    bus.dbg_addr   = dbg;
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] a, b, rdi;
    rst = 1'b1;
    bus.RegWrite_w = 1'b0; bus.rd_w = 5'd0; bus.result_w = 32'd0;
    bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; bus.dbg_addr = 5'd0;

    // reset for two cycles, then every index reads zero
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
      check("reset_rd1", {32'd0, bus.rd1_d}, 64'd0);
    end
    check("reset_cnt", bus.wb_count, 64'd0);
    check("reset_dbg", {32'd0, bus.dbg_data}, 64'd0);

    // x5 write visible next cycle, debug one cycle after that
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
    check("x5_rd1", {32'd0, bus.rd1_d}, 64'h0000_0000_DEAD_BEEF);
    check("x5_cnt", bus.wb_count, 64'd1);
    drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd5);
    check("x5_dbg", {32'd0, bus.dbg_data}, 64'h0000_0000_DEAD_BEEF);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    check("x0_rd1", {32'd0, bus.rd1_d}, 64'd0);
    check("x0_cnt", bus.wb_count, 64'd1);

    // same-cycle write/read of x7
    drive(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd0);
`ifdef WB_REGFILE_BYPASS_EN
    check("byp_rd1", {32'd0, bus.rd1_d}, 64'h0000_0000_A5A5_A5A5);
    check("byp_rd2", {32'd0, bus.rd2_d}, 64'h0000_0000_A5A5_A5A5);
`else
    check("byp_rd1", {32'd0, bus.rd1_d}, 64'h1);
    check("byp_rd2", {32'd0, bus.rd2_d}, 64'h1);
`endif
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd0);
    check("x7_next", {32'd0, bus.rd1_d}, 64'h0000_0000_A5A5_A5A5);
    check("x7_cnt", bus.wb_count, 64'd3);

    // reset beats a simultaneous write
    drive(1'b1, 1'b1, 5'd3, 32'hFF, 5'd3, 5'd5, 5'd0);
    check("rst_force", {32'd0, bus.rd1_d}, 64'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 5'd0);
    check("rst_x3", {32'd0, bus.rd1_d}, 64'd0);
    check("rst_x5", {32'd0, bus.rd2_d}, 64'd0);
    check("rst_cnt", bus.wb_count, 64'd0);

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 5'd1, 32'(i), 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0, 5'd0);
    check("cnt4_15", {60'd0, bus4.wb_count}, 64'd15);
    check("x1_last", {32'd0, bus.rd1_d}, 64'd14);
    drive(1'b0, 1'b1, 5'd2, 32'h55, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd0, 5'd0);
    check("cnt4_wrap", {60'd0, bus4.wb_count}, 64'd0);
    check("cnt64_16", bus.wb_count, 64'd16);

    // randomized traffic with frequent index collisions and occasional reset
    for (int i = 0; i < 3000; i++) begin
      rdi = 5'($urandom_range(0, 31));
      a   = ($urandom_range(0, 2) == 0) ? rdi : 5'($urandom_range(0, 31));
      b   = ($urandom_range(0, 2) == 0) ? rdi : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), rdi, $urandom,
            a, b, 5'($urandom_range(0, 31)));
    end

    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
